// File: rtl/blake2_pkg.sv
// Shared constants, controller state type and block byte-lane mapping
// for the BLAKE2s streaming front end.
package blake2_pkg;

    localparam int BLOCK_BYTES = 64;
    localparam int BLOCK_BITS  = BLOCK_BYTES * 8;
    localparam int LEN_W       = 64;
    // Byte count inside a block runs 0..64 inclusive, so it needs 7 bits.
    localparam int CNT_W       = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_INIT,
        ST_FILL,
        ST_WAIT_NEXT,
        ST_WAIT_FINAL,
        ST_DONE
    } state_t;

    // MSB position of byte idx inside the 512-bit block: byte 0 sits at [511:504].
    function automatic logic [8:0] byte_msb(input logic [5:0] idx);
        return 9'(BLOCK_BITS - 1) - {idx, 3'b000};
    endfunction

endpackage

// File: rtl/blake2s_block_buf.sv
// 64-byte block packer: writes one byte at the current fill index,
// tracks the fill count and clears both on request.
module blake2s_block_buf
    import blake2_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_wr,
    input  logic [7:0]            i_data,
    output logic [BLOCK_BITS-1:0] o_block,
    output logic [CNT_W-1:0]      o_count
);

    logic [BLOCK_BITS-1:0] r_block;
    logic [CNT_W-1:0]      r_count;
    logic                  w_full;

    // Count 64 is the only value with the top bit set.
    assign w_full  = r_count[CNT_W-1];
    assign o_block = r_block;
    assign o_count = r_count;

    // Block storage and fill index; clear wins over a same-cycle write.
    // NOTE: the block register is reset (not just cleared on init) because it
    // drives core_block directly, which must read zero out of reset; every
    // clocked update uses non-blocking assignments so readers see the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_block <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_block <= '0;
            r_count <= '0;
        end else if (i_wr && !w_full) begin
            r_block[byte_msb(r_count[5:0]) -: 8] <= i_data;
            r_count <= r_count + 7'd1;
        end
    end

endmodule

// File: rtl/blake2s_stream_ctrl.sv
// Streaming front end for the BLAKE2s core: packs a byte stream into
// 64-byte blocks, issues init/next/final commands with the running length,
// and captures the truncated digest.
module blake2s_stream_ctrl
    import blake2_pkg::*;
#(
    parameter int DIGEST_BITS = 88,
    parameter int BLOCK_BYTES = blake2_pkg::BLOCK_BYTES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic                   core_init,
    output logic                   core_next,
    output logic                   core_final,
    output logic [BLOCK_BITS-1:0]  core_block,
    output logic [LEN_W-1:0]       core_length,
    input  logic                   core_ready,
    input  logic [255:0]           core_digest,
    input  logic                   core_digest_valid,
    output logic [DIGEST_BITS-1:0] digest,
    output logic                   digest_valid
);

    state_t                 r_state;
    logic                   r_core_init;
    logic                   r_core_next;
    logic                   r_core_final;
    logic                   r_skip;
    logic                   r_digest_valid;
    logic [LEN_W-1:0]       r_total;
    logic [LEN_W-1:0]       r_core_length;
    logic [DIGEST_BITS-1:0] r_digest;

    logic [CNT_W-1:0]       w_count;
    logic                   w_full;
    logic                   w_accept;
    logic                   w_start;
    logic                   w_next_done;
    logic                   w_buf_clr;

    assign w_full      = (w_count == CNT_W'(BLOCK_BYTES));
    assign s_ready     = (r_state == ST_FILL) && (w_count < CNT_W'(BLOCK_BYTES));
    assign w_accept    = s_valid && s_ready;
    assign w_start     = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && s_valid && core_ready;
    assign w_next_done = (r_state == ST_WAIT_NEXT) && !r_skip && core_ready;
    // The buffer is emptied at init and once the core has taken a non-final block.
    assign w_buf_clr   = w_start || w_next_done;

    assign core_init    = r_core_init;
    assign core_next    = r_core_next;
    assign core_final   = r_core_final;
    assign core_length  = r_core_length;
    assign digest       = r_digest;
    assign digest_valid = r_digest_valid;

    blake2s_block_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_buf_clr),
        .i_wr    (w_accept),
        .i_data  (s_data),
        .o_block (core_block),
        .o_count (w_count)
    );

    // Only the top DIGEST_BITS of the core hash are kept.
    generate
        if (DIGEST_BITS < 256) begin : g_unused
            logic w_unused_digest_lsbs;
            assign w_unused_digest_lsbs = ^core_digest[255-DIGEST_BITS:0];
        end
    endgenerate

    // Controller FSM: command pulses, running length and digest capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_core_init    <= 1'b0;
            r_core_next    <= 1'b0;
            r_core_final   <= 1'b0;
            r_skip         <= 1'b0;
            r_digest_valid <= 1'b0;
            r_total        <= '0;
            r_core_length  <= '0;
            r_digest       <= '0;
        end else begin
            r_core_init  <= 1'b0;
            r_core_next  <= 1'b0;
            r_core_final <= 1'b0;
            // r_skip marks the command cycle itself, when core_ready has not
            // yet had a chance to fall in response to the command.
            r_skip       <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start) begin
                        r_core_init    <= 1'b1;
                        r_digest_valid <= 1'b0;
                        r_total        <= '0;
                        r_core_length  <= '0;
                        r_skip         <= 1'b1;
                        r_state        <= ST_WAIT_INIT;
                    end
                end
                ST_WAIT_INIT: begin
                    if (!r_skip && core_ready) begin
                        r_state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (w_accept) begin
                        r_total <= r_total + 64'd1;
                        if (s_last) begin
                            r_core_final  <= 1'b1;
                            r_core_length <= r_total + 64'd1;
                            r_skip        <= 1'b1;
                            r_state       <= ST_WAIT_FINAL;
                        end
                    end else if (w_full && s_valid && core_ready) begin
                        // A full block goes out as non-final only once another
                        // byte is waiting; that byte is taken after the refill.
                        r_core_next   <= 1'b1;
                        r_core_length <= r_total;
                        r_skip        <= 1'b1;
                        r_state       <= ST_WAIT_NEXT;
                    end
                end
                ST_WAIT_NEXT: begin
                    if (w_next_done) begin
                        r_state <= ST_FILL;
                    end
                end
                ST_WAIT_FINAL: begin
                    // A digest_valid still high from an earlier hash is not
                    // trusted in the cycle the final command is issued.
                    if (!r_skip && core_digest_valid) begin
                        r_digest       <= core_digest[255 -: DIGEST_BITS];
                        r_digest_valid <= 1'b1;
                        r_state        <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blake2s_stream_ctrl.sv
// Directed bench for blake2s_stream_ctrl with a behavioural core model and
// a command scoreboard.
module tb_blake2s_stream_ctrl;

    localparam int DIGEST_BITS = 88;
    localparam int LAT         = 6;
    localparam int HOLD        = 10;
    localparam logic [255:0] IV =
        256'h6B08E647_BB67AE85_3C6EF372_A54FF53A_510E527F_9B05688C_1F83D9AB_5BE0CD19;

    typedef enum logic [1:0] {C_INIT, C_NEXT, C_FINAL} cmd_e;
    typedef struct {
        cmd_e         kind;
        logic [63:0]  len;
        logic [511:0] blk;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [7:0]             s_data;
    logic                   s_valid;
    logic                   s_last;
    logic                   s_ready;
    logic                   core_init;
    logic                   core_next;
    logic                   core_final;
    logic [511:0]           core_block;
    logic [63:0]            core_length;
    logic                   core_ready;
    logic                   model_ready;
    logic                   hold_low;
    logic [255:0]           core_digest;
    logic                   core_digest_valid;
    logic [DIGEST_BITS-1:0] digest;
    logic                   digest_valid;

    int                     checks = 0;
    int                     errors = 0;
    exp_t                   sb_q[$];
    logic [DIGEST_BITS-1:0] dig_q[$];
    logic [DIGEST_BITS-1:0] last_exp;
    logic [7:0]             msg [0:255];
    time                    t_cdv;

    assign core_ready = model_ready & ~hold_low;

    always #5 clk = ~clk;

    blake2s_stream_ctrl #(.DIGEST_BITS(DIGEST_BITS)) dut (
        .clk               (clk),
        .rst               (rst),
        .s_data            (s_data),
        .s_valid           (s_valid),
        .s_last            (s_last),
        .s_ready           (s_ready),
        .core_init         (core_init),
        .core_next         (core_next),
        .core_final        (core_final),
        .core_block        (core_block),
        .core_length       (core_length),
        .core_ready        (core_ready),
        .core_digest       (core_digest),
        .core_digest_valid (core_digest_valid),
        .digest            (digest),
        .digest_valid      (digest_valid)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stand-in compression: position- and length-sensitive mixing.
    function automatic logic [255:0] mix(input logic [255:0] acc, input logic [511:0] blk,
                                         input logic [63:0] len);
        return {acc[254:0], acc[255]} ^ blk[511:256] ^ {blk[127:0], blk[255:128]} ^ {192'd0, len};
    endfunction

    // Behavioural core: goes busy LAT cycles per command, checks each command
    // against the scoreboard, presents the digest after a final.
    initial begin : core_model
        logic [255:0] acc;
        int           busy;
        logic         fin;
        exp_t         e;
        cmd_e         k;
        acc = '0; busy = 0; fin = 1'b0;
        model_ready = 1'b1; core_digest_valid = 1'b0; core_digest = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_ready = 1'b1; core_digest_valid = 1'b0; core_digest = '0;
                busy = 0; fin = 1'b0;
            end else begin
                if (busy > 0) begin
                    busy--;
                    if (busy == 0) begin
                        model_ready = 1'b1;
                        if (fin) begin
                            core_digest = acc; core_digest_valid = 1'b1;
                            t_cdv = $time; fin = 1'b0;
                        end
                    end
                end
                if (core_init || core_next || core_final) begin
                    check("cmd_onehot", 512'($countones({core_init, core_next, core_final})), 512'(1));
                    k = core_init ? C_INIT : (core_next ? C_NEXT : C_FINAL);
                    check("cmd_expected", 512'(sb_q.size() != 0), 512'(1));
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("cmd_kind", 512'(k), 512'(e.kind));
                        if (e.kind != C_INIT) begin
                            check("cmd_length", 512'(core_length), 512'(e.len));
                            check("cmd_block", core_block, e.blk);
                        end
                    end
                    if (core_init) begin
                        check("init_clears_dv", 512'(digest_valid), 512'(0));
                        acc = IV; core_digest_valid = 1'b0;
                    end else begin
                        acc = mix(acc, core_block, core_length);
                        fin = core_final;
                    end
                    model_ready = 1'b0; busy = LAT;
                end
            end
        end
    end

    task automatic load_str(input string s);
        for (int i = 0; i < s.len(); i++) msg[i] = s[i];
    endtask

    // Pushes the commands (and digest) a correct controller must produce.
    task automatic push_expected(input int n, input int n_send);
        exp_t         e;
        logic [255:0] acc;
        int           nblk;
        e.kind = C_INIT; e.len = '0; e.blk = '0;
        sb_q.push_back(e);
        if (n_send < n) return;
        acc  = IV;
        nblk = (n + 63) / 64;
        for (int k = 0; k < nblk; k++) begin
            e.blk  = '0;
            e.kind = (k == nblk - 1) ? C_FINAL : C_NEXT;
            e.len  = 64'((k == nblk - 1) ? n : 64 * (k + 1));
            for (int j = 0; j < 64; j++)
                if (64 * k + j < n) e.blk[511 - 8 * j -: 8] = msg[64 * k + j];
            sb_q.push_back(e);
            acc = mix(acc, e.blk, e.len);
        end
        dig_q.push_back(acc[255 -: DIGEST_BITS]);
    endtask

    // Streams msg[0..n_send-1]; optionally holds core_ready low for HOLD
    // cycles once the block boundary before byte hold_at is reached.
    task automatic send_msg(input int n, input int n_send, input int hold_at);
        int i, guard, hold_cnt;
        push_expected(n, n_send);
        i = 0; guard = 0; hold_cnt = 0;
        while (i < n_send && guard < 3000) begin
            @(negedge clk);
            guard++;
            s_valid = 1'b1; s_data = msg[i]; s_last = (i == n - 1);
            if (i == hold_at && hold_cnt < HOLD) begin
                hold_low = 1'b1; hold_cnt++;
                check("stall_quiet", 512'({s_ready, core_init, core_next, core_final}), 512'(0));
            end else begin
                hold_low = 1'b0;
                if (s_ready) i++;
            end
        end
        check("send_done", 512'(i), 512'(n_send));
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; hold_low = 1'b0;
    endtask

    task automatic wait_digest(input string tag);
        int cyc;
        cyc = 0;
        while (!digest_valid && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_valid"}, 512'(digest_valid), 512'(1));
        if (digest_valid) check({tag, "_dv_latency"}, 512'($time - t_cdv), 512'(10));
        if (dig_q.size() != 0) begin
            last_exp = dig_q.pop_front();
            check({tag, "_digest"}, 512'(digest), 512'(last_exp));
        end
        check({tag, "_sb_empty"}, 512'(sb_q.size()), 512'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, 512'(s_ready), 512'(0));
        check({tag, "_cmds"}, 512'({core_init, core_next, core_final}), 512'(0));
        check({tag, "_block"}, core_block, 512'(0));
        check({tag, "_length"}, 512'(core_length), 512'(0));
        check({tag, "_digest"}, 512'(digest), 512'(0));
        check({tag, "_digest_valid"}, 512'(digest_valid), 512'(0));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; hold_low = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);

        // Single short message.
        load_str("flamingo");
        send_msg(8, 8, -1);
        wait_digest("flamingo");

        // Exactly one full block: must go out as final, never as next.
        for (int i = 0; i < 64; i++) msg[i] = 8'(i);
        send_msg(64, 64, -1);
        wait_digest("len64");

        // One byte past a block boundary.
        for (int i = 0; i < 65; i++) msg[i] = 8'(8'hA0 + i);
        send_msg(65, 65, -1);
        wait_digest("len65");

        // Core stalls at the first block boundary of a three-block message.
        for (int i = 0; i < 130; i++) msg[i] = 8'(i * 7 + 3);
        send_msg(130, 130, 64);
        wait_digest("len130_stall");

        // Reset after 20 bytes of a 40-byte message.
        for (int i = 0; i < 40; i++) msg[i] = 8'(8'h55 ^ i);
        send_msg(40, 20, -1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_rst");
        check("mid_rst_sb_empty", 512'(sb_q.size()), 512'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load_str("flamingo");
        send_msg(8, 8, -1);
        wait_digest("flamingo_after_rst");

        // Back-to-back messages: result holds until the next init.
        for (int i = 0; i < 10; i++) msg[i] = 8'(8'hC3 + 5 * i);
        send_msg(10, 10, -1);
        wait_digest("b2b_a");
        repeat (3) begin
            @(negedge clk);
            check("b2b_hold_valid", 512'(digest_valid), 512'(1));
            check("b2b_hold_digest", 512'(digest), 512'(last_exp));
        end
        for (int i = 0; i < 70; i++) msg[i] = 8'(8'h11 * i + 1);
        send_msg(70, 70, -1);
        wait_digest("b2b_b");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/blake2s_stream_ctrl.md
# blake2s_stream_ctrl

Streaming front-end controller for the BLAKE2s core. It accepts a message as a byte stream and packs it into 64-byte blocks. It drives the core's init/next/final command handshake with the running byte count, then captures the truncated 88-bit digest. It is the hardware initiator for the core command interface and replaces the software stimulus used in simulation.

## Interface
Parameters:
- DIGEST_BITS, 88, truncated digest width; multiple of 8, ≤256; core is configured for the same outlen.
- BLOCK_BYTES, 64, BLAKE2s block size; fixed, not for override.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_data  in  8  message byte.
- s_valid  in  1  s_data valid.
- s_last  in  1  with s_valid, marks the final byte of the message.
- s_ready  out  1  byte accepted when s_valid && s_ready.
- core_init  out  1  one-cycle init command.
- core_next  out  1  one-cycle compress command for a non-final block.
- core_final  out  1  one-cycle compress command for the final block.
- core_block  out  512  block; byte i at [511-8i -: 8].
- core_length  out  64  total message bytes up to and including this block.
- core_ready  in  1  core idle; commands issue only when high.
- core_digest  in  256  core hash; byte 0 at [255:248].
- core_digest_valid  in  1  core_digest valid after final.
- digest  out  DIGEST_BITS  core_digest[255 -: DIGEST_BITS], byte 0 at MSB.
- digest_valid  out  1  digest holds a completed result.

## Operation
- FSM states: IDLE, WAIT_INIT, FILL, WAIT_NEXT, WAIT_FINAL, DONE.
- IDLE: s_ready=0. When s_valid && core_ready, pulse core_init, clear digest_valid, and go to WAIT_INIT.
- WAIT_INIT / WAIT_NEXT: ignore core_ready in the first cycle after the command. Then wait for core_ready=1.
  - WAIT_INIT exits to FILL.
  - WAIT_NEXT clears the buffer and byte count, then exits to FILL.
- FILL: s_ready = (count<64).
  - On accept, write the byte at index count, then count++ and total++.
  - If s_last is accepted, pulse core_final with the current block and core_length=total, then go to WAIT_FINAL.
  - If count==64, s_valid=1 and core_ready=1, pulse core_next with core_length=total and go to WAIT_NEXT. The byte is not consumed that cycle.
  - A full block is never sent as core_next until a further byte is known to exist. This guarantees the final flag lands on the true last block.
- Unused bytes of the final block are zero. The buffer is cleared on init and after every next.
- WAIT_FINAL: on core_digest_valid, register the digest, set digest_valid=1, and go to DONE.
- DONE: behaves as IDLE. digest and digest_valid hold until the next message's init.
- core_block and core_length are stable from the command cycle until the core returns ready.
- Messages are ≥1 byte; empty messages are not supported.
- total is a 64-bit counter that wraps silently. The limit is unreachable in practice.

## Timing
- Reset: state=IDLE; all outputs 0 (s_ready, core_init, core_next, core_final, core_block, core_length, digest, digest_valid). Reset mid-message abandons the message with no core command. The core is reset by the same rst.
- Throughput: one byte per cycle in FILL. Each block boundary costs the core latency plus 2 cycles.
- Latency from the accepted s_last to the core_final pulse is 1 cycle (registered).
- digest_valid rises 1 cycle after core_digest_valid.
- Command pulses are exactly 1 cycle and mutually exclusive.
- core_ready low stalls all commands indefinitely; s_ready still follows the count in FILL.

## Structure
- Package blake2_pkg holds:
  - BLOCK_BYTES=64.
  - LEN_W=64.
  - The state enum typedef.
  - The byte-index-to-block-bit mapping function.
- Sub-module blake2s_block_buf: 64-byte packer with write-at-index, clear, and count. The FSM stays in the top level.

## Test plan
- "flamingo" (8 bytes, s_last on 'o'):
  - core_init once, then core_final with core_length=8.
  - core_block = "flamingo" in bytes 0..7, bytes 8..63 zero.
  - digest = core_digest[255:168]; compare against b2sum -ablake2s -l88.
- Exactly 64 bytes (0x00..0x3F): no core_next; a single core_final with core_length=64 and byte 63=0x3F.
- 65 bytes:
  - core_next with core_length=64.
  - Then core_final with core_length=65, block byte 0 = byte 64, bytes 1..63 zero.
- Core backpressure: hold core_ready low 10 cycles at the block boundary of a 130-byte message.
  - No command pulses during the stall; s_ready=0.
  - Final core_length=130.
- Async rst asserted after byte 20 of a message:
  - All outputs 0 within the same cycle.
  - A new "flamingo" message afterwards produces the same result as the first scenario.
- Two back-to-back messages: digest_valid stays high until the second message's init, then a new digest appears.
